// File: rtl/cs_host_ctrl.sv
// rtl/cs_host_ctrl.sv - host-side command initiator for the computation-storage core
// Converts one-at-a-time RD/WR/ADD/SUB requests into core pin sequences and DQ bus handling.
module cs_host_ctrl #(
  parameter int MEM_WIDTH     = 8,
  parameter int MEM_DEPTH     = 16,
  parameter int NO_OPERATIONS = 4,
  parameter int LAT_RD        = 2,
  parameter int LAT_WR        = 2,
  parameter int LAT_ALU       = 3,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int OW = $clog2(NO_OPERATIONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OW-1:0]        cmd_op,
  input  logic [AW-1:0]        cmd_addA,
  input  logic [AW-1:0]        cmd_addB,
  input  logic [AW-1:0]        cmd_addC,
  input  logic [MEM_WIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [OW-1:0]        rsp_op,
  output logic [MEM_WIDTH-1:0] rsp_rdata,
  output logic [AW-1:0]        addA,
  output logic [AW-1:0]        addB,
  output logic [AW-1:0]        addC,
  output logic [OW-1:0]        operation_select,
  output logic [MEM_WIDTH-1:0] dq_out,
  output logic                 dq_oe,
  input  logic [MEM_WIDTH-1:0] dq_in
);

  localparam logic [OW-1:0] OP_RD = OW'(0);
  localparam logic [OW-1:0] OP_WR = OW'(1);

  typedef enum logic [1:0] {IDLE, TURN, EXEC, RESP} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [OW-1:0]        op_q;
  logic [MEM_WIDTH-1:0] wdata_q;

  function automatic logic [3:0] op_lat(input logic [OW-1:0] op);
    if (op == OP_RD)      return 4'(LAT_RD);
    else if (op == OP_WR) return 4'(LAT_WR);
    else                  return 4'(LAT_ALU);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      op_q             <= '0;
      wdata_q          <= '0;
      cmd_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_op           <= '0;
      rsp_rdata        <= '0;
      addA             <= '0;
      addB             <= '0;
      addC             <= '0;
      operation_select <= '0;
      dq_out           <= '0;
      dq_oe            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            wdata_q   <= cmd_wdata;
            addA      <= cmd_addA;
            addB      <= cmd_addB;
            addC      <= cmd_addC;
            cmd_ready <= 1'b0;
            cnt       <= op_lat(cmd_op);
            // WR gets a turnaround cycle so the core's read drive is released before we drive DQ
            operation_select <= cmd_op;
            dq_oe            <= 1'b0;
            state            <= (cmd_op == OP_WR) ? TURN : EXEC;
          end
        end
        TURN: begin
          dq_oe  <= 1'b1;
          dq_out <= wdata_q;
          cnt    <= 4'(LAT_WR);
          state  <= EXEC;
        end
        EXEC: begin
          if (cnt <= 4'd1) begin
            operation_select <= OP_RD;
            dq_oe            <= 1'b0;
            rsp_valid        <= 1'b1;
            rsp_op           <= op_q;
            rsp_rdata        <= (op_q == OP_RD) ? dq_in : '0;
            state            <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_host_ctrl.sv
// tb/tb_cs_host_ctrl.sv - directed self-checking bench for cs_host_ctrl with a behavioural core model
module tb_cs_host_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_addA = '0, cmd_addB = '0, cmd_addC = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [1:0] rsp_op;
  logic [7:0] rsp_rdata;
  logic [3:0] addA, addB, addC;
  logic [1:0] operation_select;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic [7:0] dq_in;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  logic       pre_we = 1'b0;
  logic [3:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  logic [1:0] tr_op  [24];
  logic       tr_oe  [24];
  logic [7:0] tr_out [24];
  logic [3:0] tr_a   [24];

  logic [1:0] rq_op [$];
  logic [7:0] rq_dat [$];

  cs_host_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addA(cmd_addA), .cmd_addB(cmd_addB), .cmd_addC(cmd_addC), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_rdata(rsp_rdata),
    .addA(addA), .addB(addB), .addC(addC), .operation_select(operation_select),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
  );

  always #5 clk = ~clk;

  // Core model: drives mem[addA] when the host is not driving, executes WR/ADD/SUB on each edge
  assign dq_in = dq_oe ? dq_out : mem[addA];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (operation_select == 2'd1 && dq_oe) mem[addC] <= dq_out;
    else if (operation_select == 2'd2) mem[addC] <= mem[addA] + mem[addB];
    else if (operation_select == 2'd3) mem[addC] <= mem[addA] - mem[addB];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("oe_only_on_wr", 32'(dq_oe && operation_select != 2'd1), 32'd0);
      if (rsp_valid) begin
        rq_op.push_back(rsp_op);
        rq_dat.push_back(rsp_rdata);
      end
    end
  end

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [7:0] wd,
                         output int lat, output logic [7:0] rdata);
    int g;
    @(negedge clk);
    cmd_op = op; cmd_addA = a; cmd_addB = b; cmd_addC = c; cmd_wdata = wd;
    cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    tr_op[1] = operation_select; tr_oe[1] = dq_oe; tr_out[1] = dq_out; tr_a[1] = addA;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      tr_op[lat] = operation_select; tr_oe[lat] = dq_oe; tr_out[lat] = dq_out; tr_a[lat] = addA;
    end
    rdata = rsp_rdata;
  endtask

  initial begin
    int lat;
    logic [7:0] rd;
    int g;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_dq_oe", 32'(dq_oe), 32'd0);
    check("rst_op_sel", 32'(operation_select), 32'd0);
    check("rst_addA", 32'(addA), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort a WR in its first EXEC cycle
    @(negedge clk);
    cmd_op = 2'd1; cmd_addC = 4'd6; cmd_wdata = 8'h33; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_turn_oe", 32'(dq_oe), 32'd0);
    @(negedge clk);
    check("abort_exec_oe", 32'(dq_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_async_oe", 32'(dq_oe), 32'd0);
    check("abort_async_ready", 32'(cmd_ready), 32'd1);
    check("abort_async_op", 32'(operation_select), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_rsp", 32'(rq_op.size()), 32'd0);
    check("abort_no_write", 32'(mem[6]), 32'h00);

    preload(4'd8, 8'h5A);
    preload(4'd10, 8'h30);
    preload(4'd5, 8'h12);
    preload(4'd12, 8'h10);
    preload(4'd3, 8'h20);

    run_cmd(2'd0, 4'd8, 4'd0, 4'd0, 8'h00, lat, rd);
    check("rd8_lat", 32'(lat), 32'd3);
    check("rd8_data", 32'(rd), 32'h5A);
    for (int i = 1; i <= 2; i++) begin
      check("rd8_op", 32'(tr_op[i]), 32'd0);
      check("rd8_addA", 32'(tr_a[i]), 32'd8);
      check("rd8_oe", 32'(tr_oe[i]), 32'd0);
    end

    run_cmd(2'd1, 4'd0, 4'd0, 4'd1, 8'hFF, lat, rd);
    check("wr1_lat", 32'(lat), 32'd4);
    check("wr1_rdata_zero", 32'(rd), 32'h00);
    check("wr1_turn_op", 32'(tr_op[1]), 32'd1);
    check("wr1_turn_oe", 32'(tr_oe[1]), 32'd0);
    for (int i = 2; i <= 3; i++) begin
      check("wr1_exec_op", 32'(tr_op[i]), 32'd1);
      check("wr1_exec_oe", 32'(tr_oe[i]), 32'd1);
      check("wr1_exec_dq", 32'(tr_out[i]), 32'hFF);
    end
    check("wr1_resp_oe", 32'(tr_oe[4]), 32'd0);

    run_cmd(2'd0, 4'd1, 4'd0, 4'd0, 8'h00, lat, rd);
    check("rd1_data", 32'(rd), 32'hFF);

    run_cmd(2'd2, 4'hA, 4'd5, 4'hD, 8'h00, lat, rd);
    check("add_lat", 32'(lat), 32'd4);
    for (int i = 1; i <= 3; i++) check("add_op", 32'(tr_op[i]), 32'd2);
    run_cmd(2'd0, 4'hD, 4'd0, 4'd0, 8'h00, lat, rd);
    check("add_result", 32'(rd), 32'h42);

    run_cmd(2'd3, 4'hC, 4'd3, 4'd7, 8'h00, lat, rd);
    check("sub_lat", 32'(lat), 32'd4);
    run_cmd(2'd0, 4'd7, 4'd0, 4'd0, 8'h00, lat, rd);
    check("sub_result", 32'(rd), 32'hF0);

    // Back-to-back with cmd_valid held: RD 8, WR C=2 0x77, RD 2
    repeat (2) @(negedge clk);
    rq_op.delete();
    rq_dat.delete();
    for (int k = 0; k < 3; k++) begin
      cmd_op    = (k == 1) ? 2'd1 : 2'd0;
      cmd_addA  = (k == 0) ? 4'd8 : 4'd2;
      cmd_addC  = 4'd2;
      cmd_wdata = 8'h77;
      cmd_valid = 1'b1;
      g = 0;
      while (!cmd_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      check("b2b_ready_wait", 32'(g < 20), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("b2b_busy", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_rsp_count", 32'(rq_op.size()), 32'd3);
    if (rq_op.size() == 3) begin
      check("b2b_op0", 32'(rq_op[0]), 32'd0);
      check("b2b_dat0", 32'(rq_dat[0]), 32'h5A);
      check("b2b_op1", 32'(rq_op[1]), 32'd1);
      check("b2b_dat1", 32'(rq_dat[1]), 32'h00);
      check("b2b_op2", 32'(rq_op[2]), 32'd0);
      check("b2b_dat2", 32'(rq_dat[2]), 32'h77);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
